fp_div_issue_stage: RTL and testbench
=====================================

Name: fp_div_issue_stage

Overview:
Sequential issue/retire stage wrapped around the existing combinational FP_Div datapath. It accepts an operand pair over a valid/ready handshake and registers it into FP_Div. It waits a fixed number of settle cycles for the combinational path, then registers the quotient and presents it downstream over a second valid/ready handshake. This makes FP_Div usable from the pipelined FPU as a multicycle unit, one operation in flight.

Parameters:
DATA_W, 64, operand and result width; fixed to 64, with 32-bit format carried in bits [31:0].
DIV_LAT, 4, settle cycles between operand capture and result capture; legal range 1..15.

Ports:
in_clk  input  1  clock; all state updates on the rising edge.
in_rst_n  input  1  reset, asynchronous assert, active-low.
in_req_valid  input  1  upstream operand pair valid.
out_req_ready  output  1  stage can accept operands this cycle.
in_numA  input  64  dividend; fmt 0 uses [31:0] only.
in_numB  input  64  divisor; fmt 0 uses [31:0] only.
in_fmt  input  1  1 = 64-bit FP, 0 = 32-bit FP.
out_rsp_valid  output  1  result valid.
in_rsp_ready  input  1  downstream accepts the result.
out_result  output  64  registered quotient; upper 32 bits zero when fmt 0.
out_fmt  output  1  format of the returned result.
out_div_zero  output  1  divisor was ±0 (exponent and mantissa zero for the captured format).
out_busy  output  1  high in SETTLE or HOLD.

Behaviour:
Reset:
- Asynchronous on in_rst_n low.
- State IDLE; operand regs, out_result, out_fmt, out_div_zero, counter all zero; out_rsp_valid 0.

States:
- IDLE: out_req_ready = 1. On in_req_valid, capture operands and fmt; for fmt 0, zero bits [63:32] of both operands. Load counter = DIV_LAT-1, go to SETTLE.
- SETTLE: out_req_ready = 0. If counter == 0, capture FP_Div output into out_result (fmt 0: zero [63:32]), set out_fmt and out_div_zero, go to HOLD. Otherwise decrement.
- HOLD: out_rsp_valid = 1; out_result, out_fmt and out_div_zero stay stable. out_req_ready = in_rsp_ready (combinational pass-through for back-to-back issue). On in_rsp_ready with in_req_valid, capture new operands and go to SETTLE. On in_rsp_ready alone, go to IDLE. Without in_rsp_ready, stay in HOLD indefinitely.

Timing and handshake rules:
- Latency: operands accepted at edge E0 give out_rsp_valid high after edge E0+DIV_LAT. DIV_LAT=1 means one SETTLE cycle.
- FP_Div inputs are driven only from the operand registers, never directly from the in_ ports.
- in_req_valid while out_req_ready = 0 is ignored. The producer holds its operands until accepted.
- out_div_zero is computed from the registered in_numB: [62:0] == 0 for fmt 1, [30:0] == 0 for fmt 0. The quotient itself is whatever FP_Div produces (±Inf or NaN).
- out_busy = (state != IDLE).
- Reset asserted mid-SETTLE or mid-HOLD drops the in-flight operation with no response.
- Illegal state encodings recover to IDLE.

Decomposition:
- Shared package fp_div_pkg: FMT_SP = 1'b0, FMT_DP = 1'b1, state enum {IDLE, SETTLE, HOLD}, SP_MASK = 64'h0000_0000_FFFF_FFFF, DIV_LAT_MAX = 15.
- One sub-module: the existing FP_Div, instantiated once as the combinational datapath. The control FSM and counter stay inline.

Test Plan:
- Double, DIV_LAT=4: A=4018000000000000 (6.0), B=4000000000000000 (2.0), fmt 1 → out_result=4008000000000000 (3.0), out_rsp_valid rises exactly 4 edges after acceptance, out_div_zero=0.
- Single: A=FFFFFFFF40C00000, B=0000000040000000, fmt 0 → upper operand bits masked; out_result=0000000040400000, out_fmt=0.
- Divide by zero: A=3FF0000000000000, B=8000000000000000, fmt 1 → out_result=FFF0000000000000 (−Inf), out_div_zero=1.
- Backpressure: in_rsp_ready held low 10 cycles in HOLD → out_result stable, out_req_ready=0, a new in_req_valid is not accepted. Release → one response only.
- Back-to-back: in_rsp_ready and in_req_valid both high in HOLD → new pair accepted that edge, next result valid DIV_LAT edges later, with no IDLE cycle.
- Reset mid-SETTLE: in_rst_n low for 1 ns at cycle 2 → all outputs 0 immediately, state IDLE, no response emitted after reset release.

Source files
------------

// File: rtl/fp_div_pkg.sv
// Shared types and constants for the FP divider and its issue/retire stage.
package fp_div_pkg;

  localparam logic FMT_SP = 1'b0;
  localparam logic FMT_DP = 1'b1;

  localparam logic [63:0] SP_MASK     = 64'h0000_0000_FFFF_FFFF;
  localparam int unsigned DIV_LAT_MAX = 15;
  localparam int unsigned CNT_W       = $clog2(DIV_LAT_MAX + 1);

  localparam int unsigned MAN_W = 53;
  localparam int unsigned EXP_W = 14;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_e;

  typedef struct packed {
    logic                    sign;
    logic                    is_zero;
    logic                    is_inf;
    logic                    is_nan;
    logic signed [EXP_W-1:0] expo;
    logic [MAN_W-1:0]        man;
  } fp_unpacked_t;

  function automatic logic [5:0] lzc53(input logic [MAN_W-1:0] m);
    logic [5:0] n;
    logic       found;
    n     = 6'd0;
    found = 1'b0;
    for (int i = MAN_W - 1; i >= 0; i--) begin
      if (m[i]) found = 1'b1;
      else if (!found) n = n + 6'd1;
    end
    return n;
  endfunction

  // Unpack to a common form: unbiased exponent, mantissa normalised so bit 52 is set.
  function automatic fp_unpacked_t fp_unpack(input logic [63:0] x, input logic fmt);
    fp_unpacked_t            u;
    logic [10:0]             ef;
    logic [51:0]             fr;
    logic [10:0]             emax;
    logic signed [EXP_W-1:0] bias;
    logic [5:0]              lz;
    if (fmt == FMT_DP) begin
      u.sign = x[63];
      ef     = x[62:52];
      fr     = x[51:0];
      emax   = 11'h7FF;
      bias   = 14'sd1023;
    end else begin
      u.sign = x[31];
      ef     = {3'b000, x[30:23]};
      fr     = {x[22:0], 29'd0};
      emax   = 11'h0FF;
      bias   = 14'sd127;
    end
    u.is_zero = (ef == 11'd0) && (fr == 52'd0);
    u.is_inf  = (ef == emax) && (fr == 52'd0);
    u.is_nan  = (ef == emax) && (fr != 52'd0);
    if (ef == 11'd0) begin
      lz     = lzc53({1'b0, fr});
      u.man  = {1'b0, fr} << lz;
      u.expo = 14'sd1 - bias - $signed(EXP_W'(lz));
    end else begin
      lz     = 6'd0;
      u.man  = {1'b1, fr};
      u.expo = $signed(EXP_W'(ef)) - bias;
    end
    return u;
  endfunction

endpackage

// File: rtl/fp_div_issue_stage_fp_div.sv
// Combinational IEEE-754 divider (binary32 in [31:0] or binary64), round-to-nearest-even.
module fp_div_issue_stage_fp_div
  import fp_div_pkg::*;
(
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        fmt,
  output logic [63:0] result_c
);

  localparam int unsigned QW = 56;
  localparam int unsigned NW = 108;

  fp_unpacked_t            ua, ub;
  logic [NW-1:0]           num, den;
  logic [QW-1:0]           q, qn;
  logic [QW-2:0]           qs;
  logic [63:0]             qext, mask;
  logic                    rem_nz, sticky, sign, overflow;
  logic signed [EXP_W-1:0] e_q, biased, bias, emax;
  logic [5:0]              sh;
  logic [10:0]             expf;
  logic [62:0]             dp_packed;
  logic [30:0]             sp_packed;
  logic                    dp_inc, sp_inc;
  logic                    is_nan, is_inf, is_zero;

  assign ua = fp_unpack(a, fmt);
  assign ub = fp_unpack(b, fmt);

  // Mantissa quotient scaled by 2^55, normalised so the leading one sits at bit 55.
  always_comb begin
    num    = {ua.man, 55'd0};
    den    = ub.is_zero ? NW'(1) : NW'(ub.man);
    q      = QW'(num / den);
    rem_nz = (num % den) != '0;
    if (q[QW-1]) begin
      qn  = q;
      e_q = ua.expo - ub.expo;
    end else begin
      qn  = {q[QW-2:0], 1'b0};
      e_q = ua.expo - ub.expo - 14'sd1;
    end
  end

  // Exponent rebias; results below the normal range are denormalised by right shift.
  always_comb begin
    bias     = (fmt == FMT_DP) ? 14'sd1023 : 14'sd127;
    emax     = (fmt == FMT_DP) ? 14'sd2047 : 14'sd255;
    biased   = e_q + bias;
    overflow = biased >= emax;
    if (biased >= 14'sd1) begin
      sh   = 6'd0;
      expf = biased[10:0];
    end else begin
      sh   = (biased < -14'sd62) ? 6'd63 : 6'(14'sd1 - biased);
      expf = 11'd0;
    end
    qext   = 64'(qn);
    mask   = (64'd1 << sh) - 64'd1;
    qs     = (QW-1)'(qn >> sh);
    sticky = rem_nz | ((qext & mask) != 64'd0);
  end

  // Rounding carry may ripple into the exponent field, giving Inf or promoting a subnormal.
  always_comb begin
    dp_packed = {expf, qs[54:3]};
    dp_inc    = qs[2] & (sticky | qs[1] | qs[0] | qs[3]);
    sp_packed = {expf[7:0], qs[54:32]};
    sp_inc    = qs[31] & (sticky | (|qs[30:0]) | qs[32]);
  end

  always_comb begin
    sign    = ua.sign ^ ub.sign;
    is_nan  = ua.is_nan || ub.is_nan || (ua.is_inf && ub.is_inf) || (ua.is_zero && ub.is_zero);
    is_inf  = ua.is_inf || ub.is_zero || overflow;
    is_zero = ua.is_zero || ub.is_inf;
    if (fmt == FMT_DP) begin
      if (is_nan)                    result_c = 64'h7FF8_0000_0000_0000;
      else if (ua.is_inf || ub.is_zero) result_c = {sign, 11'h7FF, 52'd0};
      else if (is_zero)              result_c = {sign, 63'd0};
      else if (is_inf)               result_c = {sign, 11'h7FF, 52'd0};
      else                           result_c = {sign, dp_packed + 63'(dp_inc)};
    end else begin
      if (is_nan)                    result_c = 64'h0000_0000_7FC0_0000;
      else if (ua.is_inf || ub.is_zero) result_c = {32'd0, sign, 8'hFF, 23'd0};
      else if (is_zero)              result_c = {32'd0, sign, 31'd0};
      else if (is_inf)               result_c = {32'd0, sign, 8'hFF, 23'd0};
      else                           result_c = {32'd0, sign, sp_packed + 31'(sp_inc)};
    end
  end

endmodule

// File: rtl/fp_div_issue_stage.sv
// Multicycle issue/retire wrapper: registers operands into the combinational divider,
// waits DIV_LAT settle cycles, then holds the registered quotient until accepted.
module fp_div_issue_stage
  import fp_div_pkg::*;
#(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned DIV_LAT = 4
) (
  input  logic              in_clk,
  input  logic              in_rst_n,
  input  logic              in_req_valid,
  output logic              out_req_ready,
  input  logic [DATA_W-1:0] in_numA,
  input  logic [DATA_W-1:0] in_numB,
  input  logic              in_fmt,
  output logic              out_rsp_valid,
  input  logic              in_rsp_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_fmt,
  output logic              out_div_zero,
  output logic              out_busy
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_LAT - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] num_a_q, num_a_d;
  logic [DATA_W-1:0] num_b_q, num_b_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              fmt_q, fmt_d;
  logic              res_fmt_q, res_fmt_d;
  logic              div_zero_q, div_zero_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] quot_c;
  logic              b_zero_c;
  logic              req_ready_c;

  fp_div_issue_stage_fp_div u_fp_div (
    .a        (num_a_q),
    .b        (num_b_q),
    .fmt      (fmt_q),
    .result_c (quot_c)
  );

  assign b_zero_c = (fmt_q == FMT_DP) ? (num_b_q[62:0] == 63'd0) : (num_b_q[30:0] == 31'd0);

  // Next-state and datapath capture.
  always_comb begin
    state_d     = state_q;
    num_a_d     = num_a_q;
    num_b_d     = num_b_q;
    fmt_d       = fmt_q;
    result_d    = result_q;
    res_fmt_d   = res_fmt_q;
    div_zero_d  = div_zero_q;
    cnt_d       = cnt_q;
    req_ready_c = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_c = 1'b1;
        if (in_req_valid) begin
          num_a_d = (in_fmt == FMT_SP) ? (in_numA & SP_MASK) : in_numA;
          num_b_d = (in_fmt == FMT_SP) ? (in_numB & SP_MASK) : in_numB;
          fmt_d   = in_fmt;
          cnt_d   = CNT_LOAD;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          result_d   = (fmt_q == FMT_SP) ? (quot_c & SP_MASK) : quot_c;
          res_fmt_d  = fmt_q;
          div_zero_d = b_zero_c;
          state_d    = HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HOLD: begin
        req_ready_c = in_rsp_ready;
        if (in_rsp_ready) begin
          if (in_req_valid) begin
            num_a_d = (in_fmt == FMT_SP) ? (in_numA & SP_MASK) : in_numA;
            num_b_d = (in_fmt == FMT_SP) ? (in_numB & SP_MASK) : in_numB;
            fmt_d   = in_fmt;
            cnt_d   = CNT_LOAD;
            state_d = SETTLE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q    <= IDLE;
      num_a_q    <= '0;
      num_b_q    <= '0;
      fmt_q      <= 1'b0;
      result_q   <= '0;
      res_fmt_q  <= 1'b0;
      div_zero_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      num_a_q    <= num_a_d;
      num_b_q    <= num_b_d;
      fmt_q      <= fmt_d;
      result_q   <= result_d;
      res_fmt_q  <= res_fmt_d;
      div_zero_q <= div_zero_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_req_ready = req_ready_c;
  assign out_rsp_valid = (state_q == HOLD);
  assign out_busy      = (state_q != IDLE);
  assign out_result    = result_q;
  assign out_fmt       = res_fmt_q;
  assign out_div_zero  = div_zero_q;

endmodule

// File: tb/tb_fp_div_issue_stage.sv
// Scoreboard bench for fp_div_issue_stage: driver pushes expected responses on acceptance,
// a negedge monitor pops and compares each retired result and its latency.
module tb_fp_div_issue_stage;

  localparam int unsigned DIV_LAT = 4;

  typedef struct {
    logic [63:0] result;
    logic        fmt;
    logic        div_zero;
    int unsigned acc_cyc;
    string       name;
  } exp_t;

  logic        in_clk;
  logic        in_rst_n;
  logic        in_req_valid;
  logic        out_req_ready;
  logic [63:0] in_numA;
  logic [63:0] in_numB;
  logic        in_fmt;
  logic        out_rsp_valid;
  logic        in_rsp_ready;
  logic [63:0] out_result;
  logic        out_fmt;
  logic        out_div_zero;
  logic        out_busy;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int unsigned cyc;
  int          checks;
  int          errors;
  bit          head_seen;

  fp_div_issue_stage #(.DATA_W(64), .DIV_LAT(DIV_LAT)) dut (
    .in_clk        (in_clk),
    .in_rst_n      (in_rst_n),
    .in_req_valid  (in_req_valid),
    .out_req_ready (out_req_ready),
    .in_numA       (in_numA),
    .in_numB       (in_numB),
    .in_fmt        (in_fmt),
    .out_rsp_valid (out_rsp_valid),
    .in_rsp_ready  (in_rsp_ready),
    .out_result    (out_result),
    .out_fmt       (out_fmt),
    .out_div_zero  (out_div_zero),
    .out_busy      (out_busy)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  initial cyc = 0;
  always @(posedge in_clk) cyc <= cyc + 1;

  always @(negedge in_clk) begin
    if (in_rst_n && out_rsp_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_rsp got result=%h while none expected", out_result);
      end else begin
        if (!head_seen) begin
          head_seen = 1'b1;
          checks++;
          if (cyc - sb_q[0].acc_cyc != DIV_LAT) begin
            errors++;
            $display("FAIL %s_latency got %0d edges want %0d", sb_q[0].name,
                     cyc - sb_q[0].acc_cyc, DIV_LAT);
          end
        end
        if (in_rsp_ready) begin
          mon_e     = sb_q.pop_front();
          head_seen = 1'b0;
          checks++;
          if (out_result !== mon_e.result || out_fmt !== mon_e.fmt ||
              out_div_zero !== mon_e.div_zero) begin
            errors++;
            $display("FAIL %s got result=%h fmt=%b dz=%b want result=%h fmt=%b dz=%b",
                     mon_e.name, out_result, out_fmt, out_div_zero,
                     mon_e.result, mon_e.fmt, mon_e.div_zero);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic fmt,
                       input logic [63:0] res, input logic dz, input string name);
    exp_t e;
    bit   done;
    done         = 1'b0;
    in_numA      = a;
    in_numB      = b;
    in_fmt       = fmt;
    in_req_valid = 1'b1;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge in_clk);
      if (out_req_ready) begin
        e.result   = res;
        e.fmt      = fmt;
        e.div_zero = dz;
        e.acc_cyc  = cyc + 1;
        e.name     = name;
        sb_q.push_back(e);
        done = 1'b1;
      end
      @(posedge in_clk);
      #1;
    end
    in_req_valid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_accept got no acceptance in 50 cycles want acceptance", name);
    end
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 40 && sb_q.size() != 0; k++) @(posedge in_clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain got %0d pending want 0", name, sb_q.size());
      sb_q.delete();
      head_seen = 1'b0;
    end
  endtask

  task automatic wait_valid(input string name);
    int k;
    k = 0;
    while (!out_rsp_valid && k < 40) begin
      @(posedge in_clk);
      #1;
      k++;
    end
    checks++;
    if (!out_rsp_valid) begin
      errors++;
      $display("FAIL %s_valid got rsp_valid=0 want 1 within 40 cycles", name);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    checks       = 0;
    errors       = 0;
    head_seen    = 1'b0;
    in_rst_n     = 1'b0;
    in_req_valid = 1'b0;
    in_numA      = '0;
    in_numB      = '0;
    in_fmt       = 1'b0;
    in_rsp_ready = 1'b1;
    repeat (2) @(posedge in_clk);
    #1;
    chk("rst_result", out_result, 64'd0);
    chk("rst_flags", {60'd0, out_rsp_valid, out_busy, out_fmt, out_div_zero}, 64'd0);
    chk("rst_ready", 64'(out_req_ready), 64'd1);
    in_rst_n = 1'b1;
    @(posedge in_clk);
    #1;

    issue(64'h4018_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b1,
          64'h4008_0000_0000_0000, 1'b0, "dp_6_div_2");
    drain("dp_6_div_2");
    issue(64'hFFFF_FFFF_40C0_0000, 64'h0000_0000_4000_0000, 1'b0,
          64'h0000_0000_4040_0000, 1'b0, "sp_6_div_2_masked");
    drain("sp_6_div_2_masked");
    issue(64'h3FF0_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1,
          64'hFFF0_0000_0000_0000, 1'b1, "dp_div_neg_zero");
    drain("dp_div_neg_zero");
    issue(64'h0000_0000_3F80_0000, 64'h0000_0000_4040_0000, 1'b0,
          64'h0000_0000_3EAA_AAAB, 1'b0, "sp_1_div_3");
    drain("sp_1_div_3");
    issue(64'h3FF0_0000_0000_0000, 64'h4008_0000_0000_0000, 1'b1,
          64'h3FD5_5555_5555_5555, 1'b0, "dp_1_div_3");
    drain("dp_1_div_3");
    issue(64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 1'b1,
          64'h7FF8_0000_0000_0000, 1'b1, "dp_0_div_0");
    drain("dp_0_div_0");
    issue(64'h1234_5678_3F80_0000, 64'hFFFF_FFFF_0000_0000, 1'b0,
          64'h0000_0000_7F80_0000, 1'b1, "sp_div_zero_masked");
    drain("sp_div_zero_masked");

    // Backpressure: result must hold and new requests must be refused.
    in_rsp_ready = 1'b0;
    issue(64'h4018_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b1,
          64'h4008_0000_0000_0000, 1'b0, "bp_hold");
    wait_valid("bp_hold");
    in_numA      = 64'h3FF0_0000_0000_0000;
    in_numB      = 64'h4008_0000_0000_0000;
    in_fmt       = 1'b1;
    in_req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge in_clk);
      chk("bp_ready", 64'(out_req_ready), 64'd0);
      chk("bp_result", out_result, 64'h4008_0000_0000_0000);
      @(posedge in_clk);
      #1;
    end
    in_req_valid = 1'b0;
    in_rsp_ready = 1'b1;
    drain("bp_hold");
    repeat (8) @(posedge in_clk);
    #1;
    chk("bp_single_rsp", {62'd0, out_rsp_valid, out_busy}, 64'd0);

    // Back-to-back: new pair accepted in the same edge the result retires.
    in_rsp_ready = 1'b0;
    issue(64'h3FF0_0000_0000_0000, 64'h4008_0000_0000_0000, 1'b1,
          64'h3FD5_5555_5555_5555, 1'b0, "b2b_first");
    wait_valid("b2b_first");
    in_rsp_ready = 1'b1;
    issue(64'h3FF0_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1,
          64'hFFF0_0000_0000_0000, 1'b1, "b2b_second");
    chk("b2b_busy_after_accept", {62'd0, out_busy, out_rsp_valid}, 64'd2);
    drain("b2b_second");

    // Reset pulse while the next operation is settling.
    issue(64'h4018_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b1,
          64'h4008_0000_0000_0000, 1'b0, "rst_mid_settle");
    @(posedge in_clk);
    #2;
    chk("pre_rst_busy", 64'(out_busy), 64'd1);
    in_rst_n = 1'b0;
    #1;
    chk("mid_rst_result", out_result, 64'd0);
    chk("mid_rst_flags", {60'd0, out_rsp_valid, out_busy, out_fmt, out_div_zero}, 64'd0);
    in_rst_n = 1'b1;
    sb_q.delete();
    head_seen = 1'b0;
    repeat (10) @(posedge in_clk);
    #1;
    chk("post_rst_idle", {62'd0, out_rsp_valid, out_busy}, 64'd0);

    issue(64'hFFFF_FFFF_40C0_0000, 64'h0000_0000_4000_0000, 1'b0,
          64'h0000_0000_4040_0000, 1'b0, "post_rst_sp");
    drain("post_rst_sp");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
